return_address_stack: RTL and testbench

Return-address predictor for the RV32I fetch path: the consuming end of the jump-and-link path. It decodes each retiring JAL/JALR, pushes the link address (PC+4) on calls, and pops it on returns. On a return it presents the popped address as the predicted JALR target, so fetch can redirect before the register file resolves rs1. The storage is a circular LIFO with overwrite-on-full semantics, and a flush clears it after a pipeline redirect.

---
 rtl/return_address_stack_if.sv | 28 ++
 rtl/return_address_stack.sv | 75 +++++++
 tb/tb_return_address_stack.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/return_address_stack_if.sv
// return_address_stack_if: retire-side bus of the return-address stack; RAS_STATS_EN adds the statistics counters
interface return_address_stack_if #(
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH)
);
  logic             iVALID;
  logic [31:0]      iIR;
  logic [31:0]      iPC;
  logic             iFLUSH;
  logic             oPRED_VALID;
  logic [31:0]      oPRED_PC;
  logic             oEMPTY;
  logic             oFULL;
  logic [PTR_W:0]   oCOUNT;
`ifdef RAS_STATS_EN
  logic [15:0]      oOVF_CNT;
  logic [15:0]      oUNF_CNT;
  modport master (output iVALID, iIR, iPC, iFLUSH,
                  input oPRED_VALID, oPRED_PC, oEMPTY, oFULL, oCOUNT, oOVF_CNT, oUNF_CNT);
  modport slave (input iVALID, iIR, iPC, iFLUSH,
                 output oPRED_VALID, oPRED_PC, oEMPTY, oFULL, oCOUNT, oOVF_CNT, oUNF_CNT);
`else
  modport master (output iVALID, iIR, iPC, iFLUSH,
                  input oPRED_VALID, oPRED_PC, oEMPTY, oFULL, oCOUNT);
  modport slave (input iVALID, iIR, iPC, iFLUSH,
                 output oPRED_VALID, oPRED_PC, oEMPTY, oFULL, oCOUNT);
`endif
endinterface

// File: rtl/return_address_stack.sv
// return_address_stack: RV32I return-address predictor, circular LIFO with overwrite-on-full
// Optional RAS_STATS_EN adds saturating overflow/underflow counters.
module return_address_stack #(
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input logic                   iCLK,
  input logic                   iRST,
  return_address_stack_if.slave bus
);
  localparam logic [PTR_W:0]   C_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W:0]   C_FULL = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W-1:0] T_ONE  = PTR_W'(1);
  logic [31:0]      r_mem [DEPTH];
  logic [PTR_W-1:0] r_tp;
  logic [PTR_W:0]   r_count;
  logic [4:0]       w_rd, w_rs1;
  logic             w_rd_lnk, w_rs1_lnk, w_jal, w_jalr;
  logic             w_push, w_pop, w_repl, w_ins, w_empty, w_full;
  logic [31:0]      w_link;
  logic [PTR_W-1:0] w_tp_inc;
  assign w_rd      = bus.iIR[11:7];
  assign w_rs1     = bus.iIR[19:15];
  assign w_rd_lnk  = (w_rd == 5'd1) || (w_rd == 5'd5);
  assign w_rs1_lnk = (w_rs1 == 5'd1) || (w_rs1 == 5'd5);
  assign w_jal     = bus.iIR[6:0] == 7'b1101111;
  assign w_jalr    = (bus.iIR[6:0] == 7'b1100111) && (bus.iIR[14:12] == 3'd0);
  assign w_push    = bus.iVALID && ((w_jal && w_rd_lnk) || (w_jalr && w_rd_lnk && (!w_rs1_lnk || w_rd == w_rs1)));
  assign w_pop     = bus.iVALID && w_jalr && !w_rd_lnk && w_rs1_lnk;
  assign w_repl    = bus.iVALID && w_jalr && w_rd_lnk && w_rs1_lnk && (w_rd != w_rs1);
  assign w_empty   = r_count == '0;
  assign w_full    = r_count == C_FULL;
  // a replace with nothing to pop degenerates to a plain push
  assign w_ins     = w_push || (w_repl && w_empty);
  assign w_link    = bus.iPC + 32'd4;
  assign w_tp_inc  = r_tp + T_ONE;
  assign bus.oPRED_VALID = !iRST && (w_pop || w_repl) && !w_empty;
  assign bus.oPRED_PC    = (iRST || w_empty) ? 32'd0 : r_mem[r_tp];
  assign bus.oEMPTY      = iRST || w_empty;
  assign bus.oFULL       = !iRST && w_full;
  assign bus.oCOUNT      = iRST ? '0 : r_count;
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r_tp    <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (bus.iFLUSH) begin
      r_tp    <= '0;
      r_count <= '0;
    end else if (w_repl && !w_empty) begin
      r_mem[r_tp] <= w_link;
    end else if (w_ins) begin
      r_tp            <= w_tp_inc;
      r_mem[w_tp_inc] <= w_link;
      if (!w_full) r_count <= r_count + C_ONE;
    end else if (w_pop && !w_empty) begin
      r_tp    <= r_tp - T_ONE;
      r_count <= r_count - C_ONE;
    end
  end
`ifdef RAS_STATS_EN
  logic [15:0] r_ovf, r_unf;
  assign bus.oOVF_CNT = r_ovf;
  assign bus.oUNF_CNT = r_unf;
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r_ovf <= '0;
      r_unf <= '0;
    end else if (!bus.iFLUSH) begin
      if (w_ins && w_full && r_ovf != 16'hFFFF) r_ovf <= r_ovf + 16'd1;
      if ((w_pop || w_repl) && w_empty && r_unf != 16'hFFFF) r_unf <= r_unf + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_return_address_stack.sv
// tb_return_address_stack: directed test-plan steps plus random traffic checked against a queue model
module tb_return_address_stack;
  localparam int DEPTH = 4;
  logic iCLK = 1'b0;
  logic iRST = 1'b1;
  int n_chk = 0, n_fail = 0;
  logic [31:0] q[$];
  logic [15:0] m_ovf = 0, m_unf = 0;
  logic last_pv, last_empty;
  logic [31:0] last_ppc;
  return_address_stack_if #(.DEPTH(DEPTH)) bus();
  return_address_stack #(.DEPTH(DEPTH)) dut (.iCLK(iCLK), .iRST(iRST), .bus(bus));
  always #5 iCLK = ~iCLK;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  function automatic logic [31:0] jal(input logic [4:0] rd);
    return {20'h00010, rd, 7'b1101111};
  endfunction
  function automatic logic [31:0] jalr(input logic [4:0] rd, input logic [4:0] rs1);
    return {12'h000, rs1, 3'b000, rd, 7'b1100111};
  endfunction
  // 0 none, 1 push, 2 pop, 3 pop-then-push
  function automatic int classify(input logic v, input logic [31:0] ir);
    logic [4:0] rd = ir[11:7];
    logic [4:0] rs = ir[19:15];
    bit ld = (rd == 1) || (rd == 5);
    bit ls = (rs == 1) || (rs == 5);
    if (!v) return 0;
    if (ir[6:0] == 7'b1101111) return ld ? 1 : 0;
    if (ir[6:0] != 7'b1100111 || ir[14:12] != 3'd0) return 0;
    if (!ld) return ls ? 2 : 0;
    if (!ls || rd == rs) return 1;
    return 3;
  endfunction
  task automatic step(input logic v, input logic [31:0] ir, input logic [31:0] pc,
                      input logic fl, input logic rs);
    int a;
    int sz;
    logic [31:0] top;
    bus.iVALID = v;
    bus.iIR    = ir;
    bus.iPC    = pc;
    bus.iFLUSH = fl;
    iRST       = rs;
    #1;
    a   = classify(v, ir);
    sz  = q.size();
    top = (sz != 0) ? q[$] : 32'd0;
    chk("pred_valid", bus.oPRED_VALID, (!rs && (a == 2 || a == 3) && sz != 0) ? 1 : 0);
    chk("pred_pc", bus.oPRED_PC, rs ? 32'd0 : top);
    chk("count", 32'(bus.oCOUNT), rs ? 0 : 32'(sz));
    chk("empty", bus.oEMPTY, (rs || sz == 0) ? 1 : 0);
    chk("full", bus.oFULL, (!rs && sz == DEPTH) ? 1 : 0);
`ifdef RAS_STATS_EN
    chk("ovf_cnt", bus.oOVF_CNT, m_ovf);
    chk("unf_cnt", bus.oUNF_CNT, m_unf);
`endif
    last_pv    = bus.oPRED_VALID;
    last_ppc   = bus.oPRED_PC;
    last_empty = bus.oEMPTY;
    @(posedge iCLK);
    if (rs) begin
      q.delete();
      m_ovf = 0;
      m_unf = 0;
    end else if (fl) begin
      q.delete();
    end else begin
      if (a == 1 && sz == DEPTH && m_ovf != 16'hFFFF) m_ovf++;
      if ((a == 2 || a == 3) && sz == 0 && m_unf != 16'hFFFF) m_unf++;
      if (a == 1 || (a == 3 && sz == 0)) begin
        q.push_back(pc + 32'd4);
        if (q.size() > DEPTH) void'(q.pop_front());
      end else if (a == 2 && sz != 0) begin
        void'(q.pop_back());
      end else if (a == 3) begin
        q[$] = pc + 32'd4;
      end
    end
    #1;
  endtask
  task automatic idle();
    step(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
  endtask
  logic [4:0] regs [4] = '{5'd0, 5'd1, 5'd5, 5'd6};
  initial begin
    logic [31:0] exp_ret [4] = '{32'h54, 32'h44, 32'h34, 32'h24};
    step(1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
    step(1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
    idle();
    step(1'b1, jal(5'd1), 32'h100, 1'b0, 1'b0);
    step(1'b1, jalr(5'd0, 5'd1), 32'h200, 1'b0, 1'b0);
    chk("cr_pv", last_pv, 1);
    chk("cr_pc", last_ppc, 32'h104);
    idle();
    chk("cr_empty", last_empty, 1);
    for (int i = 1; i <= 4; i++) step(1'b1, jal(5'd1), 32'(i * 16), 1'b0, 1'b0);
    chk("ovf_full", bus.oFULL, 1);
    step(1'b1, jal(5'd1), 32'h50, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, jalr(5'd0, 5'd1), 32'h900, 1'b0, 1'b0);
      chk("ovf_ret_pv", last_pv, 1);
      chk("ovf_ret_pc", last_ppc, exp_ret[i]);
    end
    step(1'b1, jalr(5'd0, 5'd5), 32'h900, 1'b0, 1'b0);
    chk("ovf_ret5_pv", last_pv, 0);
`ifdef RAS_STATS_EN
    chk("ovf_stat", bus.oOVF_CNT, 1);
    chk("unf_stat", bus.oUNF_CNT, 1);
`endif
    step(1'b1, jal(5'd1), 32'h200, 1'b0, 1'b0);
    step(1'b1, jalr(5'd1, 5'd5), 32'h300, 1'b0, 1'b0);
    chk("repl_pc", last_ppc, 32'h204);
    chk("repl_top", bus.oPRED_PC, 32'h304);
    chk("repl_cnt", 32'(bus.oCOUNT), 1);
    step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    step(1'b1, jalr(5'd1, 5'd1), 32'h400, 1'b0, 1'b0);
    chk("same_pv", last_pv, 0);
    chk("same_cnt", 32'(bus.oCOUNT), 1);
    chk("same_top", bus.oPRED_PC, 32'h404);
    step(1'b1, jal(5'd1), 32'h500, 1'b0, 1'b0);
    step(1'b1, jal(5'd1), 32'h600, 1'b1, 1'b0);
    chk("fl_cnt", 32'(bus.oCOUNT), 0);
    chk("fl_empty", bus.oEMPTY, 1);
    step(1'b1, jalr(5'd0, 5'd1), 32'h700, 1'b0, 1'b0);
    chk("fl_ret_pv", last_pv, 0);
    for (int i = 0; i < 3; i++) step(1'b1, jal(5'd5), 32'h1000 + 32'(i * 8), 1'b0, 1'b0);
    step(1'b1, jal(5'd0), 32'h2000, 1'b0, 1'b0);
    step(1'b1, jalr(5'd0, 5'd6), 32'h2004, 1'b0, 1'b0);
    chk("nl_cnt", 32'(bus.oCOUNT), 3);
    step(1'b1, jal(5'd1), 32'h3000, 1'b0, 1'b1);
    chk("rst_cnt", 32'(bus.oCOUNT), 0);
    chk("rst_pc", bus.oPRED_PC, 0);
    for (int n = 0; n < 600; n++) begin
      logic [31:0] ir, pc;
      logic [4:0] rd, rs1;
      int k;
      rd  = ($urandom_range(0, 4) == 4) ? 5'($urandom) : regs[$urandom_range(0, 3)];
      rs1 = ($urandom_range(0, 4) == 4) ? 5'($urandom) : regs[$urandom_range(0, 3)];
      k   = $urandom_range(0, 9);
      ir  = $urandom;
      ir[11:7]  = rd;
      ir[19:15] = rs1;
      if (k < 4) ir[6:0] = 7'b1101111;
      else begin
        ir[6:0]   = 7'b1100111;
        ir[14:12] = (k == 9) ? 3'($urandom_range(1, 7)) : 3'd0;
      end
      pc = ($urandom_range(0, 19) == 0) ? 32'hFFFFFFFC : ($urandom & 32'hFFFFFFFC);
      step($urandom_range(0, 7) != 0, ir, pc, $urandom_range(0, 15) == 0, $urandom_range(0, 99) == 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
